// File: rtl/vga_frame_sink.sv
// Pixel-plot frame sink: 160x120x3 frame buffer written by a drawing engine and
// scanned out as 640x480@60 Hz VGA with each stored pixel shown as a 4x4 block.
module vga_frame_sink #(
    parameter logic [2:0] BACKGROUND = 3'd0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] VGA_X,
    input  logic [6:0] VGA_Y,
    input  logic [2:0] VGA_COLOR,
    input  logic       plot,
    output logic       busy,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    localparam logic [14:0] LAST_ADDR = 15'd19199;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t      state_reg, state_next;
    logic [14:0] clr_addr_reg, clr_addr_next;

    logic        mem_we;
    logic [14:0] mem_wa;
    logic [2:0]  mem_wd;
    logic [2:0]  mem [0:19199];
    logic [2:0]  rd_data_reg;
    logic [14:0] rd_addr;
    logic [14:0] plot_addr;
    logic [14:0] y_ext;

    logic        pix_en_reg;
    logic [9:0]  h_reg, v_reg;
    logic        h_active, v_active, hs_n, vs_n;
    logic        hs1_reg, vs1_reg, blank1_reg;
    logic        hs_reg, vs_reg, blank_reg;
    logic [2:0]  rgb_reg;
    logic [7:0]  chan [3];

    assign y_ext     = {8'd0, VGA_Y};
    assign plot_addr = (y_ext << 7) + (y_ext << 5) + {7'd0, VGA_X};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    // The clear owns the write port; drawing-engine writes only land in RUN.
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        mem_we        = 1'b0;
        mem_wa        = '0;
        mem_wd        = '0;
        case (state_reg)
            CLEAR: begin
                mem_we = 1'b1;
                mem_wa = clr_addr_reg;
                mem_wd = BACKGROUND;
                if (clr_addr_reg == LAST_ADDR)
                    state_next = RUN;
                else
                    clr_addr_next = clr_addr_reg + 15'd1;
            end
            RUN: begin
                if (plot && (VGA_X < 8'd160) && (VGA_Y < 7'd120)) begin
                    mem_we = 1'b1;
                    mem_wa = plot_addr;
                    mem_wd = VGA_COLOR;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign h_active = (h_reg < 10'd640);
    assign v_active = (v_reg < 10'd480);
    assign hs_n     = !((h_reg >= 10'd656) && (h_reg <= 10'd751));
    assign vs_n     = !((v_reg >= 10'd490) && (v_reg <= 10'd491));
    // Address held at 0 outside the active area so the read never leaves the array.
    assign rd_addr  = (h_active && v_active)
                    ? (({7'd0, v_reg[9:2]} << 7) + ({7'd0, v_reg[9:2]} << 5) + {7'd0, h_reg[9:2]})
                    : 15'd0;

    // Old data is returned on a same-address read during write.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
        if (pix_en_reg)
            rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pix_en_reg <= 1'b0;
            h_reg      <= '0;
            v_reg      <= '0;
            hs1_reg    <= 1'b1;
            vs1_reg    <= 1'b1;
            blank1_reg <= 1'b0;
            hs_reg     <= 1'b1;
            vs_reg     <= 1'b1;
            blank_reg  <= 1'b0;
            rgb_reg    <= '0;
        end else begin
            pix_en_reg <= ~pix_en_reg;
            if (pix_en_reg) begin
                if (h_reg == 10'd799) begin
                    h_reg <= '0;
                    v_reg <= (v_reg == 10'd524) ? 10'd0 : v_reg + 10'd1;
                end else begin
                    h_reg <= h_reg + 10'd1;
                end
                hs1_reg    <= hs_n;
                vs1_reg    <= vs_n;
                blank1_reg <= h_active && v_active && (state_reg == RUN);
                hs_reg     <= hs1_reg;
                vs_reg     <= vs1_reg;
                blank_reg  <= blank1_reg;
                rgb_reg    <= blank1_reg ? rd_data_reg : 3'd0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_expand
            assign chan[gi] = {8{rgb_reg[gi]}};
        end
    endgenerate

    assign VGA_R       = chan[2];
    assign VGA_G       = chan[1];
    assign VGA_B       = chan[0];
    assign VGA_HS      = hs_reg;
    assign VGA_VS      = vs_reg;
    assign VGA_BLANK_N = blank_reg;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = pix_en_reg;
    assign busy        = (state_reg == CLEAR);

endmodule

// File: tb/tb_vga_frame_sink.sv
// Scoreboard bench for vga_frame_sink: a cycle model predicts each scanned pixel
// word when the counters are sampled and checks it when the output stage shows it.
module tb_vga_frame_sink;

    localparam logic [2:0] BG = 3'd5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] vga_x = '0;
    logic [6:0] vga_y = '0;
    logic [2:0] vga_color = '0;
    logic       plot = 1'b0;
    logic       busy;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

    vga_frame_sink #(.BACKGROUND(BG)) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .VGA_X      (vga_x),
        .VGA_Y      (vga_y),
        .VGA_COLOR  (vga_color),
        .plot       (plot),
        .busy       (busy),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b),
        .VGA_HS     (vga_hs),
        .VGA_VS     (vga_vs),
        .VGA_BLANK_N(vga_blank_n),
        .VGA_SYNC_N (vga_sync_n),
        .VGA_CLK    (vga_clk)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          h;
        int          v;
        logic [26:0] word;
    } pix_t;

    pix_t       sb[$];
    pix_t       cur;
    bit         popped = 0;
    bit         pe_m = 0;
    bit         run_m = 0;
    int         h_m = 0, v_m = 0, clr_m = 0;
    int         cyc = 0;
    int         run_at = -1;
    logic [2:0] mem_m [19200];

    int         busy_cnt = 0;
    bit         hs_prev = 1;
    int         last_fall = -1;
    int         blank_cnt = 0;

    function automatic logic [26:0] expect_word(input int h, input int v);
        logic       hs, vs, act;
        logic [2:0] col;
        hs  = !(h >= 656 && h <= 751);
        vs  = !(v >= 490 && v <= 491);
        act = (h < 640) && (v < 480) && run_m;
        col = 3'd0;
        if (act) col = mem_m[(v / 4) * 160 + h / 4];
        return {hs, vs, act, {8{col[2]}}, {8{col[1]}}, {8{col[0]}}};
    endfunction

    function automatic bit interesting(input int h);
        return (h <= 8) || (h >= 36 && h <= 47) || (h >= 380 && h <= 383) || (h % 32 == 0) ||
               h == 639 || h == 640 || h == 655 || h == 656 || h == 751 || h == 752 || h == 799;
    endfunction

    task automatic model_step();
        if (reset) begin
            pe_m = 0; h_m = 0; v_m = 0; clr_m = 0; run_m = 0; run_at = -1;
            popped = 0;
            sb.delete();
            sb.push_back('{-1, -1, {1'b1, 1'b1, 1'b0, 24'd0}});
        end else begin
            popped = 0;
            if (pe_m) begin
                cur = sb.pop_front();
                popped = 1;
                sb.push_back('{h_m, v_m, expect_word(h_m, v_m)});
                if (h_m == 799) begin
                    h_m = 0;
                    v_m = (v_m == 524) ? 0 : v_m + 1;
                end else begin
                    h_m++;
                end
            end
            if (!run_m) begin
                mem_m[clr_m] = BG;
                if (clr_m == 19199) begin
                    run_m = 1;
                    run_at = cyc;
                end else begin
                    clr_m++;
                end
            end else if (plot && vga_x < 160 && vga_y < 120) begin
                mem_m[vga_y * 160 + vga_x] = vga_color;
            end
            pe_m = !pe_m;
        end
    endtask

    task automatic observe();
        if (popped && interesting(cur.h))
            check($sformatf("pix h%0d v%0d", cur.h, cur.v),
                  {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b}, cur.word);
        if ((cyc % 256 == 0) || (clr_m >= 19195 && (run_at < 0 || cyc < run_at + 3))) begin
            check("busy", busy, !run_m);
            check("vga_clk", vga_clk, pe_m);
            check("sync_n", vga_sync_n, 0);
        end
        if (busy) busy_cnt++;
        if (reset) begin
            last_fall = -1;
            hs_prev = 1;
        end else begin
            if (vga_blank_n) blank_cnt++;
            if (hs_prev && !vga_hs) begin
                if (last_fall >= 0) begin
                    check("hs_period", cyc - last_fall, 1600);
                    if (run_at < 0)
                        check("blank_during_clear", blank_cnt, 0);
                    else if (last_fall > run_at + 8)
                        check("blank_per_line", blank_cnt, 1280);
                end
                last_fall = cyc;
                blank_cnt = 0;
            end
            if (!hs_prev && vga_hs && last_fall >= 0)
                check("hs_low", cyc - last_fall, 192);
            hs_prev = vga_hs;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic do_plot(input int x, input int y, input int c);
        vga_x = 8'(x);
        vga_y = 7'(y);
        vga_color = 3'(c);
        plot = 1'b1;
        tick();
        plot = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        check("rst_hs", vga_hs, 1);
        check("rst_vs", vga_vs, 1);
        check("rst_blank_n", vga_blank_n, 0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_busy", busy, 1);
        check("rst_vga_clk", vga_clk, 0);
        check("rst_sync_n", vga_sync_n, 0);
        reset = 1'b0;

        // Partial clear, then reset mid-clear to restart it.
        repeat (5000) tick();
        reset = 1'b1;
        tick();
        busy_cnt = 0;
        tick();
        reset = 1'b0;

        // Plots while clearing, including one on the last clear cycle, are dropped.
        for (int i = 0; i < 19300; i++) begin
            vga_x = (i == 200) ? 8'd10 : (i == 19199) ? 8'd1 : 8'd0;
            vga_y = (i == 100) ? 7'd0 : 7'd5;
            vga_color = 3'd7;
            plot = (i == 100) || (i == 200) || (i == 19199);
            tick();
            plot = 1'b0;
        end
        check("busy_clear_len", busy_cnt, 19200);
        check("busy_after_clear", busy, 0);

        do_plot(10, 5, 2);
        do_plot(160, 4, 7);
        do_plot(255, 5, 7);
        do_plot(0, 120, 7);

        // Raster source: rows 7..8, crossing the x=159 -> 0 wrap.
        for (int y = 7; y <= 8; y++)
            for (int x = 0; x < 160; x++)
                do_plot(x, y, 1);

        for (int n = 0; n < 60000 && v_m < 37; n++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
